// File: rtl/imem_load_ctrl_pkg.sv
// Shared types and defaults for the instruction-memory load controller.
// States, command bytes and sizing helpers.
package imem_load_ctrl_pkg;

  localparam int NB_ADDR_DEF = 8;
  localparam int NB_DATA_DEF = 32;
  localparam int NB_BYTE     = 8;

  localparam logic [7:0] CMD_LOAD_DEF = 8'h4C;
  localparam logic [7:0] CMD_RUN_DEF  = 8'h52;
  localparam logic [7:0] CMD_STEP_DEF = 8'h53;
  localparam logic [7:0] CMD_HALT_DEF = 8'h48;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_CNT  = 3'd1,
    ST_LOAD_WORD = 3'd2,
    ST_RUN       = 3'd3,
    ST_STEP      = 3'd4
  } state_e;

  function automatic logic [31:0] depth_words(input int nb_addr);
    return 32'(1) << (nb_addr - 2);
  endfunction

endpackage

// File: rtl/imem_load_ctrl_if.sv
// Byte-stream, memory-write and run-control bundle of the load controller.
// slave = controller side, master = environment side.
interface imem_load_ctrl_if;

  logic        i_rx_valid;
  logic [7:0]  i_rx_byte;
  logic        i_pipe_halted;
  logic        o_we;
  logic [31:0] o_inst_addr;
  logic [31:0] o_instr_data;
  logic        o_halt;
  logic        o_done;
  logic        o_err;
  logic [2:0]  o_state;

  modport slave (
    input  i_rx_valid,
    input  i_rx_byte,
    input  i_pipe_halted,
    output o_we,
    output o_inst_addr,
    output o_instr_data,
    output o_halt,
    output o_done,
    output o_err,
    output o_state
  );

  modport master (
    output i_rx_valid,
    output i_rx_byte,
    output i_pipe_halted,
    input  o_we,
    input  o_inst_addr,
    input  o_instr_data,
    input  o_halt,
    input  o_done,
    input  o_err,
    input  o_state
  );

endinterface

// File: rtl/imem_load_ctrl_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words.
// o_word/o_word_vld are valid in the cycle of the 4th byte.
module imem_load_ctrl_byte_packer
  import imem_load_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_clr,
  input  logic               i_vld,
  input  logic [NB_BYTE-1:0] i_byte,
  output logic               o_word_vld,
  output logic [31:0]        o_word
);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] sr_q, sr_d;

  always_comb begin
    idx_d = idx_q;
    sr_d  = sr_q;
    if (i_clr) begin
      idx_d = '0;
      sr_d  = '0;
    end else if (i_vld) begin
      idx_d = idx_q + 2'd1;
      sr_d  = {i_byte, sr_q[31:8]};
    end
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      idx_q <= '0;
      sr_q  <= '0;
    end else begin
      idx_q <= idx_d;
      sr_q  <= sr_d;
    end
  end

  assign o_word_vld = i_vld && !i_clr && (idx_q == 2'd3);
  assign o_word     = {i_byte, sr_q[31:8]};

endmodule

// File: rtl/imem_load_ctrl.sv
// Loads UART bytes into instruction memory and gates the pipeline halt:
// run until HALT retires, or single-step one cycle.
module imem_load_ctrl
  import imem_load_ctrl_pkg::*;
#(
  parameter int         NB_ADDR  = NB_ADDR_DEF,
  parameter int         NB_DATA  = NB_DATA_DEF,
  parameter logic [7:0] CMD_LOAD = CMD_LOAD_DEF,
  parameter logic [7:0] CMD_RUN  = CMD_RUN_DEF,
  parameter logic [7:0] CMD_STEP = CMD_STEP_DEF,
  parameter logic [7:0] CMD_HALT = CMD_HALT_DEF
) (
  input logic              clk,
  input logic              i_rst_n,
  imem_load_ctrl_if.slave  bus
);

  localparam int          CW    = NB_ADDR - 1;
  localparam logic [31:0] DEPTH = depth_words(NB_ADDR);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NB_ADDR-1:0]   addr_q, addr_d;
  logic                 we_q, we_d;
  logic [31:0]          wa_q, wa_d;
  logic [NB_DATA-1:0]   data_q, data_d;
  logic                 halt_q, halt_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic        pk_vld;
  logic [31:0] pk_word;

  // Packer only holds bytes while a load is in progress.
  imem_load_ctrl_byte_packer u_packer (
    .clk       (clk),
    .i_rst_n   (i_rst_n),
    .i_clr     (state_q != ST_LOAD_WORD),
    .i_vld     (bus.i_rx_valid),
    .i_byte    (bus.i_rx_byte),
    .o_word_vld(pk_vld),
    .o_word    (pk_word)
  );

  logic        rx;
  logic [31:0] n_ext;
  logic        n_bad;
  logic        is_load, is_run, is_step, is_halt;

  assign rx      = bus.i_rx_valid;
  assign n_ext   = {24'd0, bus.i_rx_byte};
  assign n_bad   = (n_ext == 32'd0) || (n_ext > DEPTH);
  assign is_load = rx && (bus.i_rx_byte == CMD_LOAD);
  assign is_run  = rx && (bus.i_rx_byte == CMD_RUN);
  assign is_step = rx && (bus.i_rx_byte == CMD_STEP);
  assign is_halt = rx && (bus.i_rx_byte == CMD_HALT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    wa_d    = wa_q;
    data_d  = data_q;
    halt_d  = 1'b1;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        unique case (1'b1)
          is_load: state_d = ST_LOAD_CNT;
          is_run:  state_d = ST_RUN;
          is_step: state_d = ST_STEP;
          default: ;
        endcase
      end
      ST_LOAD_CNT: begin
        if (rx) begin
          if (n_bad) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_d   = CW'(bus.i_rx_byte);
            addr_d  = '0;
            state_d = ST_LOAD_WORD;
          end
        end
      end
      ST_LOAD_WORD: begin
        if (pk_vld) begin
          we_d   = 1'b1;
          wa_d   = 32'(addr_q);
          data_d = NB_DATA'(pk_word);
          addr_d = addr_q + NB_ADDR'(4);
          cnt_d  = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_RUN: begin
        halt_d = 1'b0;
        // Either stop source ends the run; one done pulse even if both fire.
        if (bus.i_pipe_halted || is_halt) begin
          halt_d  = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_STEP: begin
        halt_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wa_q    <= '0;
      data_q  <= '0;
      halt_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      data_q  <= data_d;
      halt_q  <= halt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.o_we         = we_q;
  assign bus.o_inst_addr  = wa_q;
  assign bus.o_instr_data = 32'(data_q);
  assign bus.o_halt       = halt_q;
  assign bus.o_done       = done_q;
  assign bus.o_err        = err_q;
  assign bus.o_state      = state_q;

endmodule
